// File: rtl/guard_pkg.sv
// Shared types and constants for the guard sprite motion block.
package guard_pkg;

  // Direction code carried on direction_guard; bit 2 set means "hold still".
  typedef enum logic [2:0] {
    LEFT     = 3'b000,
    RIGHT    = 3'b001,
    DOWN     = 3'b010,
    UP       = 3'b011,
    HOLD_DIR = 3'b100
  } dir_e;

  // Guard behaviour state.
  typedef enum logic [1:0] {
    WALK  = 2'd0,
    HOLD  = 2'd1,
    ALERT = 2'd2
  } state_e;

  // Sprites are square, this many pixels on a side.
  localparam int SPRITE_SIZE = 16;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vertical-sync level into the Clk domain and emits a one-cycle
// tick on each synchronized rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic tick
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchronizer followed by an edge-detect history flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its old
      // neighbour value, which is what builds a real shift chain.
      meta_q <= level;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign tick = sync_q & ~prev_q;

endmodule

// File: rtl/guard_motion.sv
// Guard sprite controller: walks on frame ticks with clamping, animates,
// and switches to a timed ALERT when the player is seen ahead.
module guard_motion
  import guard_pkg::*;
#(
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 623,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 463,
  parameter int STEP        = 1,
  parameter int VIEW_RANGE  = 64,
  parameter int ALERT_TICKS = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] direction_guard,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] guard_x,
  output logic [9:0] guard_y,
  output logic [1:0] guard_facing,
  output logic       moving,
  output logic [1:0] anim_frame,
  output logic       player_spotted
);

  localparam int CW = (ALERT_TICKS > 2) ? $clog2(ALERT_TICKS) : 1;
  localparam logic [CW-1:0]     ALERT_LOAD = CW'(ALERT_TICKS - 1);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic signed [10:0] RANGE_S = 11'(VIEW_RANGE);
  localparam logic signed [10:0] SIDE_S  = 11'(SPRITE_SIZE);

  logic          tick;
  state_e        state;
  logic [CW-1:0] alert_cnt;
  logic [2:0]    anim_sub;

  logic signed [10:0] gx_s, gy_s, dx, dy;
  logic signed [10:0] nx, ny, fwd, perp;
  logic               stepped, spot;

  frame_tick_sync u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .level (frame_clk),
    .tick  (tick)
  );

  assign gx_s = $signed({1'b0, guard_x});
  assign gy_s = $signed({1'b0, guard_y});
  assign dx   = $signed({1'b0, player_x}) - gx_s;
  assign dy   = $signed({1'b0, player_y}) - gy_s;

  // Candidate next position for the requested direction, clamped to limits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    nx = gx_s;
    ny = gy_s;
    unique case (dir_e'({1'b0, direction_guard[1:0]}))
      LEFT:    nx = (gx_s - STEP_S < X_MIN_S) ? X_MIN_S : gx_s - STEP_S;
      RIGHT:   nx = (gx_s + STEP_S > X_MAX_S) ? X_MAX_S : gx_s + STEP_S;
      DOWN:    ny = (gy_s + STEP_S > Y_MAX_S) ? Y_MAX_S : gy_s + STEP_S;
      UP:      ny = (gy_s - STEP_S < Y_MIN_S) ? Y_MIN_S : gy_s - STEP_S;
      default: ;
    endcase
    stepped = (nx != gx_s) || (ny != gy_s);
  end

  // Player ahead along the facing direction and within sprite width sideways.
  always_comb begin
    fwd  = dx;
    perp = dy;
    unique case (dir_e'({1'b0, guard_facing}))
      LEFT:    begin fwd = -dx; perp = dy; end
      RIGHT:   begin fwd = dx;  perp = dy; end
      DOWN:    begin fwd = dy;  perp = dx; end
      UP:      begin fwd = -dy; perp = dx; end
      default: ;
    endcase
    spot = (fwd > 11'sd0) && (fwd <= RANGE_S) &&
           (perp > -SIDE_S) && (perp < SIDE_S);
  end

  // Behaviour FSM with registered outputs; only frame ticks advance it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= HOLD;
      alert_cnt      <= '0;
      guard_x        <= 10'(X_INIT);
      guard_y        <= 10'(Y_INIT);
      guard_facing   <= 2'b01;
      moving         <= 1'b0;
      anim_sub       <= 3'd0;
      anim_frame     <= 2'd0;
      player_spotted <= 1'b0;
    end else if (tick) begin
      if (state == ALERT) begin
        // Direction and sightings are ignored until the timer runs out.
        moving <= 1'b0;
        if (alert_cnt == '0) begin
          state          <= direction_guard[2] ? HOLD : WALK;
          player_spotted <= 1'b0;
        end else begin
          alert_cnt <= alert_cnt - 1'b1;
        end
      end else if (spot) begin
        // Seeing the player beats any requested move on the same tick.
        state          <= ALERT;
        alert_cnt      <= ALERT_LOAD;
        player_spotted <= 1'b1;
        moving         <= 1'b0;
      end else if (direction_guard[2]) begin
        state      <= HOLD;
        moving     <= 1'b0;
        anim_sub   <= 3'd0;
        anim_frame <= 2'd0;
      end else begin
        state        <= WALK;
        guard_facing <= direction_guard[1:0];
        guard_x      <= nx[9:0];
        guard_y      <= ny[9:0];
        moving       <= stepped;
        if (stepped) begin
          anim_sub <= anim_sub + 3'd1;
          if (anim_sub == 3'd7) anim_frame <= anim_frame + 2'd1;
        end else begin
          anim_sub   <= 3'd0;
          anim_frame <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_guard_motion.sv
// Directed bench for guard_motion: walking, clamping, hold, animation,
// spotting boundaries, alert timeout and asynchronous reset.
module tb_guard_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [2:0] direction_guard = 3'b100;
  logic [9:0] player_x = '0;
  logic [9:0] player_y = '0;
  logic [9:0] guard_x, guard_y;
  logic [1:0] guard_facing, anim_frame;
  logic       moving, player_spotted;

  int total = 0;
  int bad   = 0;

  guard_motion dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .direction_guard(direction_guard),
    .player_x       (player_x),
    .player_y       (player_y),
    .guard_x        (guard_x),
    .guard_y        (guard_y),
    .guard_facing   (guard_facing),
    .moving         (moving),
    .anim_frame     (anim_frame),
    .player_spotted (player_spotted)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full frame_clk pulse; the tick and its update land well inside it.
  task automatic frame_edge();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_edge();
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    // Reset state
    player_x = 10'd0; player_y = 10'd0; direction_guard = 3'b001;
    do_reset();
    check("rst_x", guard_x, 320);
    check("rst_y", guard_y, 240);
    check("rst_facing", guard_facing, 1);
    check("rst_moving", moving, 0);
    check("rst_anim", anim_frame, 0);
    check("rst_spot", player_spotted, 0);

    // Walk right three frames
    frames(3);
    check("right_x", guard_x, 323);
    check("right_y", guard_y, 240);
    check("right_facing", guard_facing, 1);
    check("right_moving", moving, 1);

    // No frame edge: nothing changes
    repeat (20) @(negedge Clk);
    check("idle_x", guard_x, 323);
    check("idle_moving", moving, 1);

    // Hold for five frames
    direction_guard = 3'b100;
    frames(5);
    check("hold_x", guard_x, 323);
    check("hold_facing", guard_facing, 1);
    check("hold_moving", moving, 0);
    check("hold_anim", anim_frame, 0);

    // Down then up
    direction_guard = 3'b010;
    frames(2);
    check("down_y", guard_y, 242);
    check("down_facing", guard_facing, 2);
    direction_guard = 3'b011;
    frame_edge();
    check("up_y", guard_y, 241);
    check("up_facing", guard_facing, 3);

    // Animation over 16 moving ticks, then cleared by a hold tick
    do_reset();
    direction_guard = 3'b001;
    frames(7);
    check("anim_t7", anim_frame, 0);
    frame_edge();
    check("anim_t8", anim_frame, 1);
    frames(7);
    check("anim_t15", anim_frame, 1);
    frame_edge();
    check("anim_t16", anim_frame, 2);
    check("anim_x16", guard_x, 336);
    direction_guard = 3'b100;
    frame_edge();
    check("anim_hold", anim_frame, 0);

    // Left clamp at X_MIN
    do_reset();
    direction_guard = 3'b000;
    frames(319);
    check("left_x1", guard_x, 1);
    frame_edge();
    check("clamp_x_a", guard_x, 0);
    check("clamp_mv_a", moving, 1);
    frame_edge();
    check("clamp_x_b", guard_x, 0);
    check("clamp_mv_b", moving, 0);
    frame_edge();
    check("clamp_x_c", guard_x, 0);
    check("clamp_mv_c", moving, 0);
    check("clamp_facing", guard_facing, 0);

    // Sight boundaries while holding, facing right from (320,240)
    do_reset();
    direction_guard = 3'b100;
    player_x = 10'd385; player_y = 10'd240;
    frame_edge();
    check("range65_spot", player_spotted, 0);
    player_x = 10'd384; player_y = 10'd256;
    frame_edge();
    check("perp16_spot", player_spotted, 0);
    player_x = 10'd384; player_y = 10'd255;
    frame_edge();
    check("range64_spot", player_spotted, 1);

    // Alert entry beats a move, then times out after 120 ticks
    do_reset();
    direction_guard = 3'b001;
    player_x = 10'd380; player_y = 10'd245;
    frame_edge();
    check("alert_spot", player_spotted, 1);
    check("alert_x", guard_x, 320);
    check("alert_moving", moving, 0);
    player_x = 10'd0; player_y = 10'd0;
    frames(119);
    check("alert_t119_spot", player_spotted, 1);
    check("alert_t119_x", guard_x, 320);
    frame_edge();
    check("alert_t120_spot", player_spotted, 0);
    frame_edge();
    check("resume_x", guard_x, 321);
    check("resume_moving", moving, 1);

    // Asynchronous reset in the middle of an alert
    do_reset();
    direction_guard = 3'b001;
    frames(5);
    check("pre_alert_x", guard_x, 325);
    player_x = 10'd385; player_y = 10'd245;
    frame_edge();
    check("mid_alert_spot", player_spotted, 1);
    frames(69);
    @(negedge Clk) Reset = 1'b1;
    #1;
    check("arst_x", guard_x, 320);
    check("arst_y", guard_y, 240);
    check("arst_spot", player_spotted, 0);
    check("arst_moving", moving, 0);
    check("arst_facing", guard_facing, 1);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    player_x = 10'd0; player_y = 10'd0;
    frame_edge();
    check("post_rst_x", guard_x, 321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
